// File: rtl/icache.sv
// rtl/icache.sv - direct-mapped read-only instruction cache, one-word frames
// Optional hit/miss counters when ICACHE_STATS_EN is defined.
module icache #(
  parameter int SETS = 16
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  input  logic        halt,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 30 - IDX_W;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] MISS = 1'b1;

  logic [0:0]       state;
  logic [SETS-1:0]  valid;
  logic [TAG_W-1:0] tag_q  [SETS];
  logic [31:0]      data_q [SETS];
  logic [29:0]      miss_word;

  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] miss_idx;
  logic [TAG_W-1:0] tag;
  logic [TAG_W-1:0] miss_tag;
  logic             hit;
  logic             launch;
  logic             fill;
  logic [1:0]       unused_addr_bits;

  assign idx              = imemaddr[IDX_W+1:2];
  assign tag              = imemaddr[31:IDX_W+2];
  assign unused_addr_bits = imemaddr[1:0];
  assign miss_idx         = miss_word[IDX_W-1:0];
  assign miss_tag         = miss_word[29:IDX_W];

  assign hit    = (state == IDLE) && imemREN && valid[idx] && (tag_q[idx] == tag);
  assign launch = (state == IDLE) && imemREN && !hit && !halt;
  assign fill   = (state == MISS) && !iwait;

  assign ihit     = hit;
  assign imemload = hit ? data_q[idx] : 32'h0;
  assign iREN     = (state == MISS);
  assign iaddr    = iREN ? {miss_word, 2'b00} : 32'h0;

  // A launched miss always runs to completion, whatever the datapath does meanwhile.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      valid     <= '0;
      miss_word <= '0;
    end else if (launch) begin
      state     <= MISS;
      miss_word <= imemaddr[31:2];
    end else if (fill) begin
      state           <= IDLE;
      valid[miss_idx] <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (fill) begin
      tag_q[miss_idx]  <= miss_tag;
      data_q[miss_idx] <= iload;
    end
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (hit)    hit_count  <= hit_count + 32'd1;
      if (launch) miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache.sv
// tb/tb_icache.sv - scoreboard bench for icache with reference cache model and memory responder
// Honours ICACHE_STATS_EN when the design is built with it.
module tb_icache;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        halt;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  icache #(.SETS(16)) dut (
    .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr), .halt(halt),
    .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr),
    .iwait(iwait), .iload(iload)
`ifdef ICACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] data;
    int          mode;   // 0: hit same cycle, 1: miss with exact penalty, 2: no latency check
  } exp_t;

  exp_t        exp_q [$];
  logic [31:0] miss_q [$];
  int          total = 0;
  int          passed = 0;
  int          cyc = 0;
  int          issue_cyc = 0;
  int          last_waits = 0;
  int          force_wait = -1;
  int          hit_seen = 0;
  int          model_misses = 0;
  bit          mvalid [16];
  logic [25:0] mtag [16];

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [31:0] memword(input logic [31:0] a);
    if (a == 32'h0)  return 32'h3C080001;
    if (a == 32'h40) return 32'h8C020004;
    return (a * 32'h01000193) ^ 32'h5A5A0F0F;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act === want) passed++;
    else $display("FAIL %s: got %h, want %h (t=%0t)", name, act, want, $time);
  endtask

  task automatic note_fail(input string name, input string why);
    total++;
    $display("FAIL %s: %s (t=%0t)", name, why, $time);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) begin
      mvalid[i] = 1'b0;
      mtag[i]   = '0;
    end
  endtask

  function automatic bit model_hit(input logic [31:0] a);
    return mvalid[a[5:2]] && (mtag[a[5:2]] == a[31:6]);
  endfunction

  task automatic expect_miss(input logic [31:0] a);
    miss_q.push_back({a[31:2], 2'b00});
    mvalid[a[5:2]] = 1'b1;
    mtag[a[5:2]]   = a[31:6];
    model_misses++;
  endtask

  task automatic push_exp(input logic [31:0] a, input int mode);
    exp_t e;
    e.data = memword({a[31:2], 2'b00});
    e.mode = mode;
    exp_q.push_back(e);
  endtask

  task automatic wait_hit(input string name);
    bit got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge CLK);
      got = ihit;
    end
    if (!got) note_fail(name, "no ihit within 40 cycles");
  endtask

  task automatic fetch(input logic [31:0] a, input logic h);
    @(posedge CLK); #1;
    imemREN = 1'b1; imemaddr = a; halt = h; issue_cyc = cyc;
    if (model_hit(a)) begin
      push_exp(a, 0);
      wait_hit("fetch_hit");
    end else if (h) begin
      for (int k = 0; k < 5; k++) begin
        @(negedge CLK);
        check("halt_no_iren", {31'h0, iREN}, 32'h0);
      end
      @(posedge CLK); #1;
      imemREN = 1'b0; halt = 1'b0;
    end else begin
      expect_miss(a);
      push_exp(a, 1);
      wait_hit("fetch_miss");
    end
  endtask

  task automatic rand_phase(input int count);
    logic [31:0] a;
    logic [25:0] tg;
    int          ts;
    for (int n = 0; n < count; n++) begin
      ts = $urandom_range(0, 3);
      tg = (ts == 3) ? 26'h3FFFFFF : 26'(ts);
      a  = {tg, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
      fetch(a, $urandom_range(0, 9) == 0);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge CLK); #1;
        imemREN = 1'b0;
        repeat ($urandom_range(0, 2)) @(posedge CLK);
      end
    end
  endtask

  task automatic check_stats(input string tagname);
`ifdef ICACHE_STATS_EN
    @(posedge CLK); #2;
    check({tagname, "_miss_count"}, miss_count, model_misses);
    check({tagname, "_hit_count"}, hit_count, hit_seen);
`else
    if (tagname.len() < 0) note_fail(tagname, "unreachable");
`endif
  endtask

  // Memory side: random (or forced) wait states, data from memword().
  initial begin
    bit active = 1'b0;
    int rem = 0;
    int waits = 0;
    iwait = 1'b1;
    iload = 32'h0;
    forever begin
      @(posedge CLK); #1;
      if (!iREN) begin
        active = 1'b0;
        iwait  = 1'b1;
        iload  = 32'h0;
      end else begin
        if (!active) begin
          active = 1'b1;
          waits  = 0;
          rem    = (force_wait >= 0) ? force_wait : int'($urandom_range(0, 3));
          if (miss_q.size() == 0) note_fail("unexpected_miss", $sformatf("iaddr=%h", iaddr));
          else check("miss_iaddr", iaddr, miss_q.pop_front());
        end
        if (rem > 0) begin
          rem--;
          waits++;
          iwait = 1'b1;
        end else begin
          iwait      = 1'b0;
          iload      = memword(iaddr);
          last_waits = waits;
        end
      end
    end
  end

  // Monitor: every served fetch is matched against the oldest expected response.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (!nRST) begin
        hit_seen = 0;
      end else if (ihit) begin
        hit_seen++;
        if (exp_q.size() == 0) begin
          note_fail("unexpected_ihit", $sformatf("imemaddr=%h", imemaddr));
        end else begin
          e = exp_q.pop_front();
          check("imemload", imemload, e.data);
          if (e.mode == 0) check("hit_latency", cyc - issue_cyc, 0);
          if (e.mode == 1) check("miss_latency", cyc - issue_cyc, 2 + last_waits);
        end
      end else begin
        check("imemload_idle", imemload, 32'h0);
      end
    end
  end

  initial begin
    nRST = 1'b0; imemREN = 1'b0; imemaddr = 32'h0; halt = 1'b0;
    model_clear();
    #3;
    check("rst_ihit", {31'h0, ihit}, 32'h0);
    check("rst_imemload", imemload, 32'h0);
    check("rst_iren", {31'h0, iREN}, 32'h0);
    check("rst_iaddr", iaddr, 32'h0);
    repeat (2) @(negedge CLK);
    nRST = 1'b1;

    // cold miss with three wait states, then hit/conflict on frame 0
    force_wait = 3;
    fetch(32'h0, 1'b0);
    force_wait = -1;
    fetch(32'h0, 1'b0);
    fetch(32'h40, 1'b0);
    fetch(32'h0, 1'b0);
    check_stats("conflict");

    // address moves during the miss: frame 2 still filled for 0x8
    force_wait = 2;
    @(posedge CLK); #1;
    imemREN = 1'b1; imemaddr = 32'h8; halt = 1'b0; issue_cyc = cyc;
    expect_miss(32'h8);
    begin
      bit seen = 1'b0;
      for (int k = 0; k < 10 && !seen; k++) begin
        @(negedge CLK);
        seen = iREN;
      end
      if (!seen) note_fail("miss_0x8_start", "iREN never rose");
    end
    @(posedge CLK); #1;
    imemaddr = 32'hC;
    if (!model_hit(32'hC)) expect_miss(32'hC);
    push_exp(32'hC, 2);
    wait_hit("fetch_0xC");
    force_wait = -1;
    fetch(32'h8, 1'b0);

    // halt blocks misses but not hits
    fetch(32'h20, 1'b1);
    fetch(32'h0, 1'b1);

    rand_phase(150);
    check_stats("random");

    // asynchronous reset in the middle of a miss
    force_wait = 8;
    @(posedge CLK); #1;
    imemREN = 1'b1; imemaddr = 32'hABC0; halt = 1'b0;
    expect_miss(32'hABC0);
    repeat (3) @(negedge CLK);
    #2;
    nRST = 1'b0;
    #1;
    check("midrst_ihit", {31'h0, ihit}, 32'h0);
    check("midrst_imemload", imemload, 32'h0);
    check("midrst_iren", {31'h0, iREN}, 32'h0);
    check("midrst_iaddr", iaddr, 32'h0);
    miss_q.delete();
    exp_q.delete();
    model_clear();
    model_misses = 0;
    imemREN = 1'b0;
    force_wait = -1;
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
    check_stats("after_reset");

    rand_phase(50);
    check_stats("final");
    @(posedge CLK); #1;
    imemREN = 1'b0;
    repeat (2) @(negedge CLK);
    check("exp_q_drained", exp_q.size(), 0);
    check("miss_q_drained", miss_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
